// File: rtl/mux4_way_merge_if.sv
// Four-source merge bus: four valid/ready source channels and one registered
// sink port with a source tag and an accepted-beat counter.
interface mux4_way_merge_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] X1, X2, X3, X4;
   logic             V1, V2, V3, V4;
   logic             R1, R2, R3, R4;
   logic [WIDTH-1:0] OUT;
   logic [1:0]       s;
   logic             VALID;
   logic             READY;
   logic [15:0]      COUNT;

   // Merge block view
   modport slave (
      input  X1, X2, X3, X4, V1, V2, V3, V4, READY,
      output R1, R2, R3, R4, OUT, s, VALID, COUNT
   );

   // Sources and sink view
   modport master (
      output X1, X2, X3, X4, V1, V2, V3, V4, READY,
      input  R1, R2, R3, R4, OUT, s, VALID, COUNT
   );
endinterface

// File: rtl/mux4_way_merge.sv
// Round-robin merge of four valid/ready sources into one registered output
// slot. A new beat may be loaded whenever the slot is empty or is being
// drained this cycle, giving one beat per cycle at full throughput.
module mux4_way_merge #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mux4_way_merge_if.slave      bus
);

   logic [WIDTH-1:0] out_q;
   logic [1:0]       s_q;
   logic             valid_q;
   logic [1:0]       ptr_q;
   logic [15:0]      count_q;

   logic [WIDTH-1:0] x_vec [4];
   logic [3:0]       v_vec;
   logic             free;
   logic             found;
   logic [1:0]       grant_d;
   logic [3:0]       r_vec;
   logic             src_fire;

   assign x_vec[0] = bus.X1;
   assign x_vec[1] = bus.X2;
   assign x_vec[2] = bus.X3;
   assign x_vec[3] = bus.X4;
   assign v_vec    = {bus.V4, bus.V3, bus.V2, bus.V1};

   assign free = !valid_q || bus.READY;

   // Search the valids starting one past the last granted channel, wrapping
   always_comb begin
      logic [1:0] idx;
      found   = 1'b0;
      grant_d = 2'd0;
      idx     = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         idx = ptr_q + 2'(i);
         if (!found && v_vec[idx]) begin
            found   = 1'b1;
            grant_d = idx;
         end
      end
   end

   // Ready only to the winner, and never while reset is held
   assign src_fire = rst_n && free && found;

   always_comb begin
      r_vec = 4'b0000;
      if (src_fire) r_vec[grant_d] = 1'b1;
   end

   assign bus.R1    = r_vec[0];
   assign bus.R2    = r_vec[1];
   assign bus.R3    = r_vec[2];
   assign bus.R4    = r_vec[3];
   assign bus.OUT   = out_q;
   assign bus.s     = s_q;
   assign bus.VALID = valid_q;
   assign bus.COUNT = count_q;

   // Output slot: load on source transfer, empty on drain-only, else hold.
   // ptr resets to channel 4 so the first search begins at channel 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         s_q     <= 2'd0;
         valid_q <= 1'b0;
         ptr_q   <= 2'd3;
         count_q <= 16'd0;
      end else if (src_fire) begin
         out_q   <= x_vec[grant_d];
         s_q     <= grant_d;
         valid_q <= 1'b1;
         ptr_q   <= grant_d;
         count_q <= count_q + 16'd1;
      end else if (valid_q && bus.READY) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux4_way_merge.sv
// Directed bench for the four-way round-robin merge.
module tb_mux4_way_merge;
   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   mux4_way_merge_if #(.WIDTH(8)) bus ();

   mux4_way_merge #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_v(input logic [3:0] v);
      bus.V1 = v[0];
      bus.V2 = v[1];
      bus.V3 = v[2];
      bus.V4 = v[3];
   endtask

   task automatic set_x(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
      bus.X1 = a;
      bus.X2 = b;
      bus.X3 = c;
      bus.X4 = d;
   endtask

   task automatic do_reset();
      @(negedge clk);
      set_v(4'b0000);
      bus.READY = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      set_v(4'b1111);
      bus.READY = 1'b1;
      #1;
      n_tests++;
      if ({bus.VALID, bus.OUT, bus.s, bus.COUNT} !== 27'd0) begin
         n_fail++;
         $display("FAIL reset_state: VALID=%b OUT=%h s=%0d COUNT=%0d, want all 0",
                  bus.VALID, bus.OUT, bus.s, bus.COUNT);
      end
      n_tests++;
      if ({bus.R4, bus.R3, bus.R2, bus.R1} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ready: R=%b want 0000",
                  {bus.R4, bus.R3, bus.R2, bus.R1});
      end
      @(negedge clk);
      set_v(4'b0000);
      bus.READY = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      set_x(8'h00, 8'h00, 8'hA5, 8'h00);
      set_v(4'b0100);
      bus.READY = 1'b1;
      #1;
      n_tests++;
      if ({bus.R4, bus.R3, bus.R2, bus.R1} !== 4'b0100) begin
         n_fail++;
         $display("FAIL single_ready: R=%b want 0100",
                  {bus.R4, bus.R3, bus.R2, bus.R1});
      end
      @(posedge clk); #1;
      n_tests++;
      if (bus.OUT !== 8'hA5 || bus.s !== 2'd2 || bus.VALID !== 1'b1 || bus.COUNT !== 16'd1) begin
         n_fail++;
         $display("FAIL single_beat: OUT=%h s=%0d VALID=%b COUNT=%0d want A5 2 1 1",
                  bus.OUT, bus.s, bus.VALID, bus.COUNT);
      end
      @(negedge clk);
      set_v(4'b0000);
      @(posedge clk); #1;
      n_tests++;
      if (bus.VALID !== 1'b0 || bus.OUT !== 8'hA5 || bus.s !== 2'd2) begin
         n_fail++;
         $display("FAIL single_drain: VALID=%b OUT=%h s=%0d want 0 A5 2",
                  bus.VALID, bus.OUT, bus.s);
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_x [4];
      exp_x[0] = 8'h11; exp_x[1] = 8'h22; exp_x[2] = 8'h33; exp_x[3] = 8'h44;
      do_reset();
      set_x(8'h11, 8'h22, 8'h33, 8'h44);
      set_v(4'b1111);
      bus.READY = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         n_tests++;
         if (bus.s !== 2'(i % 4) || bus.OUT !== exp_x[i % 4] || bus.VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_beat%0d: s=%0d OUT=%h VALID=%b want s=%0d OUT=%h VALID=1",
                     i, bus.s, bus.OUT, bus.VALID, i % 4, exp_x[i % 4]);
         end
      end
      n_tests++;
      if (bus.COUNT !== 16'd8) begin
         n_fail++;
         $display("FAIL rr_count: COUNT=%0d want 8", bus.COUNT);
      end
      @(negedge clk);
      set_v(4'b0000);
   endtask

   task automatic test_backpressure();
      do_reset();
      set_x(8'h5A, 8'hC3, 8'h00, 8'h00);
      set_v(4'b0010);
      bus.READY = 1'b1;
      @(posedge clk);
      @(negedge clk);
      set_v(4'b0001);
      bus.READY = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_tests++;
         if (bus.R1 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_r1_cycle%0d: R1=%b want 0", i, bus.R1);
         end
         @(posedge clk); #1;
         n_tests++;
         if (bus.OUT !== 8'hC3 || bus.s !== 2'd1 || bus.VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold%0d: OUT=%h s=%0d VALID=%b want C3 1 1",
                     i, bus.OUT, bus.s, bus.VALID);
         end
         @(negedge clk);
      end
      bus.READY = 1'b1;
      #1;
      n_tests++;
      if (bus.R1 !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release_r1: R1=%b want 1", bus.R1);
      end
      @(posedge clk); #1;
      n_tests++;
      if (bus.OUT !== 8'h5A || bus.s !== 2'd0 || bus.VALID !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release_beat: OUT=%h s=%0d VALID=%b want 5A 0 1",
                  bus.OUT, bus.s, bus.VALID);
      end
   endtask

   // Runs right after backpressure: last grant was channel 1
   task automatic test_skip_idle();
      @(negedge clk);
      set_x(8'h01, 8'h02, 8'h03, 8'h9E);
      set_v(4'b1000);
      bus.READY = 1'b1;
      #1;
      n_tests++;
      if ({bus.R4, bus.R3, bus.R2, bus.R1} !== 4'b1000) begin
         n_fail++;
         $display("FAIL skip_r4: R=%b want 1000", {bus.R4, bus.R3, bus.R2, bus.R1});
      end
      @(posedge clk); #1;
      n_tests++;
      if (bus.s !== 2'd3 || bus.OUT !== 8'h9E) begin
         n_fail++;
         $display("FAIL skip_beat4: s=%0d OUT=%h want 3 9E", bus.s, bus.OUT);
      end
      @(negedge clk);
      set_v(4'b1001);
      #1;
      n_tests++;
      if ({bus.R4, bus.R3, bus.R2, bus.R1} !== 4'b0001) begin
         n_fail++;
         $display("FAIL skip_wrap_r: R=%b want 0001", {bus.R4, bus.R3, bus.R2, bus.R1});
      end
      @(posedge clk); #1;
      n_tests++;
      if (bus.s !== 2'd0 || bus.OUT !== 8'h01) begin
         n_fail++;
         $display("FAIL skip_wrap_beat: s=%0d OUT=%h want 0 01", bus.s, bus.OUT);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      set_x(8'h11, 8'h22, 8'h33, 8'h44);
      set_v(4'b0100);
      bus.READY = 1'b1;
      @(posedge clk);
      #2;
      set_v(4'b0000);
      bus.READY = 1'b0;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({bus.VALID, bus.OUT, bus.s, bus.COUNT} !== 27'd0) begin
         n_fail++;
         $display("FAIL async_reset: VALID=%b OUT=%h s=%0d COUNT=%0d want all 0",
                  bus.VALID, bus.OUT, bus.s, bus.COUNT);
      end
      @(negedge clk);
      rst_n = 1'b1;
      set_v(4'b1111);
      bus.READY = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (bus.s !== 2'd0 || bus.OUT !== 8'h11 || bus.COUNT !== 16'd1) begin
         n_fail++;
         $display("FAIL async_first_grant: s=%0d OUT=%h COUNT=%0d want 0 11 1",
                  bus.s, bus.OUT, bus.COUNT);
      end
      @(negedge clk);
      set_v(4'b0000);
   endtask

   task automatic test_count_wrap();
      do_reset();
      set_x(8'h11, 8'h22, 8'h33, 8'h44);
      set_v(4'b1111);
      bus.READY = 1'b1;
      repeat (65535) @(posedge clk);
      #1;
      n_tests++;
      if (bus.COUNT !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL wrap_preload: COUNT=%h want FFFF", bus.COUNT);
      end
      @(posedge clk); #1;
      n_tests++;
      if (bus.COUNT !== 16'h0000 || bus.s !== 2'd3 || bus.OUT !== 8'h44 || bus.VALID !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_count: COUNT=%h s=%0d OUT=%h VALID=%b want 0000 3 44 1",
                  bus.COUNT, bus.s, bus.OUT, bus.VALID);
      end
      @(negedge clk);
      set_v(4'b0000);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      bus.READY = 1'b0;
      set_v(4'b0000);
      set_x(8'h00, 8'h00, 8'h00, 8'h00);
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_skip_idle();
      test_async_reset();
      test_count_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mux4_way_merge.md
MUX4_WAY_MERGE -- requirements
Module: mux4_way_merge

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: WIDTH, default 8, data width of every channel.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 X1, X2, X3, X4  input  WIDTH each  source channel data.
REQ-006 V1, V2, V3, V4  input  1 each  source channel valid.
REQ-007 R1, R2, R3, R4  output  1 each  source channel ready, combinational.
REQ-008 OUT  output  WIDTH  merged data, registered.
REQ-009 s  output  2  source tag of OUT: 0 = channel 1, 1 = channel 2, 2 = channel 3, 3 = channel 4. Registered.
REQ-010 VALID  output  1  OUT and s hold a beat, registered.
REQ-011 READY  input  1  sink accepts the beat in this cycle.
REQ-012 COUNT  output  16  number of beats accepted from sources since reset.

Function
REQ-013 A source transfer SHALL occur on a rising edge where Vk=1 and Rk=1.
REQ-014 A sink transfer SHALL occur on a rising edge where VALID=1 and READY=1.
REQ-015 Slot free: free = !VALID | READY.
REQ-016 Grant: when free=1, the first channel with Vk=1 SHALL win. The search starts at channel ptr+1 and wraps 1->2->3->4->1.
REQ-017 Only the winning channel's Rk SHALL be 1. All Rk SHALL be 0 when free=0 or no Vk is 1.
REQ-018 Rk MAY depend combinationally on V1..V4 and READY. Sources SHALL NOT make Vk depend on Rk.
REQ-019 On a source transfer from channel k, OUT SHALL load Xk, s SHALL load k-1, and VALID SHALL be 1 at the next edge.
REQ-020 On a source transfer, ptr SHALL load k-1.
REQ-021 Simultaneous sink and source transfer: the new beat SHALL replace the old one. VALID stays 1 and full throughput of one beat per cycle is sustained.
REQ-022 Sink transfer with no source transfer: VALID SHALL go to 0. OUT and s hold their last values.
REQ-023 VALID=1 and READY=0: OUT, s, VALID and ptr SHALL hold stable, and all Rk SHALL be 0.
REQ-024 Latency: one cycle from source transfer to VALID=1. No bubble SHALL be inserted while any Vk=1 and READY=1.
REQ-025 Fairness: with all four Vk held at 1 and READY=1, grants SHALL cycle 1,2,3,4 repeatedly. No channel waits more than 3 grants.
REQ-026 COUNT SHALL increment by 1 per source transfer and wrap from 16'hFFFF to 0 without saturating.
REQ-027 Data SHALL pass unmodified. There is no arithmetic on OUT.
REQ-028 A beat is never lost and never duplicated. Each source transfer produces exactly one sink transfer.

Reset
REQ-029 When rst_n=0, the block SHALL immediately set VALID=0, OUT=0, s=0, COUNT=0 and ptr=3, without waiting for a clock edge.
REQ-030 While rst_n=0, all Rk SHALL be 0.
REQ-031 Reset asserted mid-beat SHALL discard the held beat.
REQ-032 After rst_n rises, the first grant SHALL search from channel 1.
REQ-033 Reset deassertion SHALL be synchronised externally to clk. The block assumes no reset-release metastability.

Verification
REQ-034 Single source: reset, then V3=1, X3=8'hA5, READY=1 for one cycle -> R3=1 that cycle; next cycle OUT=A5, s=2, VALID=1, COUNT=1.
REQ-035 Round-robin: X1..X4 = 11,22,33,44, all V=1, READY=1 for 8 cycles -> s sequence 0,1,2,3,0,1,2,3 with matching OUT; COUNT=8.
REQ-036 Backpressure: beat from channel 2 held, READY=0 for 5 cycles with V1=1 -> OUT, s=1 and VALID stable, R1=0 throughout; READY=1 -> R1=1, next OUT=X1, s=0.
REQ-037 Skip idle channels: ptr=0 (last grant channel 1), only V4=1 -> channel 4 granted, s=3; then only V1 and V4 valid -> channel 1 granted next.
REQ-038 Async reset: assert rst_n=0 between edges while VALID=1 -> VALID, OUT, s and COUNT go to 0 before the next edge; after release, all V=1 -> first s=0.
REQ-039 Wrap: preload 65535 transfers (or force COUNT=16'hFFFF), then one more transfer -> COUNT=0 while data flow is unaffected.
